debounce_multi: RTL and testbench

Parametrised multi-channel successor to the single-button debouncer. Each of CHANNELS raw mechanical inputs is synchronised, then debounced with a per-channel stability counter. Each channel produces a clean level, one-cycle press/release pulses, a long-press pulse and optional auto-repeat pulses. Sits between board push-buttons/switches and the control FSMs.

---
 rtl/debounce_multi_if.sv | 30 +++
 rtl/debounce_multi.sv | 155 +++++++++++++++
 tb/tb_debounce_multi.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/debounce_multi_if.sv
// debounce_multi_if: raw button inputs and the debounced event outputs.
// master drives the raw buttons; slave is the debouncer.
interface debounce_multi_if #(
   parameter int CHANNELS = 4
);
   logic [CHANNELS-1:0] button_in;
   logic [CHANNELS-1:0] db_out;
   logic [CHANNELS-1:0] press_pulse;
   logic [CHANNELS-1:0] release_pulse;
   logic [CHANNELS-1:0] long_pulse;
   logic [CHANNELS-1:0] repeat_pulse;

   modport master (
      output button_in,
      input  db_out,
      input  press_pulse,
      input  release_pulse,
      input  long_pulse,
      input  repeat_pulse
   );

   modport slave (
      input  button_in,
      output db_out,
      output press_pulse,
      output release_pulse,
      output long_pulse,
      output repeat_pulse
   );
endinterface

// File: rtl/debounce_multi.sv
// debounce_multi: per-channel 2-FF sync, stability-count debounce,
// press/release pulses, long-press pulse and optional auto-repeat.
module debounce_multi #(
   parameter int CHANNELS      = 4,
   parameter int DB_CYCLES     = 500000,
   parameter int HOLD_CYCLES   = 50000000,
   parameter int REPEAT_CYCLES = 5000000,
   parameter int ACTIVE_LOW    = 0
) (
   input logic              clk,
   input logic              reset,
   debounce_multi_if.slave  bus
);

   localparam int CNT_W  = $clog2(DB_CYCLES);
   localparam int HMAX   = (HOLD_CYCLES > REPEAT_CYCLES) ?
                           HOLD_CYCLES : REPEAT_CYCLES;
   localparam int HOLD_W = $clog2(HMAX + 1);

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DB_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

   // Idle raw level; the synchroniser resets to it so no phantom press.
   localparam logic IDLE = (ACTIVE_LOW != 0);

   typedef enum logic {
      PH_HOLD,
      PH_REPEAT
   } phase_e;

   logic [CHANNELS-1:0] sync1_q, sync1_d;
   logic [CHANNELS-1:0] sync2_q, sync2_d;
   logic [CHANNELS-1:0] s;

   logic [CNT_W-1:0]    cnt_q   [CHANNELS];
   logic [CNT_W-1:0]    cnt_d   [CHANNELS];
   logic [HOLD_W-1:0]   hold_q  [CHANNELS];
   logic [HOLD_W-1:0]   hold_d  [CHANNELS];
   phase_e              phase_q [CHANNELS];
   phase_e              phase_d [CHANNELS];

   logic [CHANNELS-1:0] db_q, db_d;
   logic [CHANNELS-1:0] press_q, press_d;
   logic [CHANNELS-1:0] rel_q, rel_d;
   logic [CHANNELS-1:0] long_q, long_d;
   logic [CHANNELS-1:0] rep_q, rep_d;
   logic [CHANNELS-1:0] accept;

   // Synchroniser inputs: plain two-stage shift of the raw buttons.
   always_comb begin
      sync1_d = bus.button_in;
      sync2_d = sync1_q;
   end

   // Polarity-normalised synchronised level: 1 means pressed.
   assign s = sync2_q ^ {CHANNELS{IDLE}};

   // Next-state logic for the debounce counter and the hold/repeat FSM.
   always_comb begin
      accept  = '0;
      db_d    = db_q;
      press_d = '0;
      rel_d   = '0;
      long_d  = '0;
      rep_d   = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         cnt_d[i]   = cnt_q[i];
         hold_d[i]  = hold_q[i];
         phase_d[i] = phase_q[i];

         if (s[i] == db_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            cnt_d[i]   = '0;
            db_d[i]    = s[i];
            accept[i]  = 1'b1;
            press_d[i] = s[i];
            rel_d[i]   = ~s[i];
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end

         // Released, or on the press/release edge: rearm the hold phase.
         if (!db_q[i] || accept[i]) begin
            hold_d[i]  = '0;
            phase_d[i] = PH_HOLD;
         end else begin
            case (phase_q[i])
               PH_HOLD: begin
                  if (hold_q[i] == HOLD_LAST) begin
                     long_d[i]  = 1'b1;
                     hold_d[i]  = '0;
                     phase_d[i] = PH_REPEAT;
                  end else begin
                     hold_d[i] = hold_q[i] + 1'b1;
                  end
               end
               PH_REPEAT: begin
                  if (REPEAT_CYCLES == 0) begin
                     hold_d[i] = '0;
                  end else if (hold_q[i] == REP_LAST) begin
                     rep_d[i]  = 1'b1;
                     hold_d[i] = '0;
                  end else begin
                     hold_d[i] = hold_q[i] + 1'b1;
                  end
               end
               default: begin
                  hold_d[i]  = '0;
                  phase_d[i] = PH_HOLD;
               end
            endcase
         end
      end
   end

   // State registers; reset aborts any count or hold with no pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= {CHANNELS{IDLE}};
         sync2_q <= {CHANNELS{IDLE}};
         db_q    <= '0;
         press_q <= '0;
         rel_q   <= '0;
         long_q  <= '0;
         rep_q   <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i]   <= '0;
            hold_q[i]  <= '0;
            phase_q[i] <= PH_HOLD;
         end
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         db_q    <= db_d;
         press_q <= press_d;
         rel_q   <= rel_d;
         long_q  <= long_d;
         rep_q   <= rep_d;
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i]   <= cnt_d[i];
            hold_q[i]  <= hold_d[i];
            phase_q[i] <= phase_d[i];
         end
      end
   end

   assign bus.db_out        = db_q;
   assign bus.press_pulse   = press_q;
   assign bus.release_pulse = rel_q;
   assign bus.long_pulse    = long_q;
   assign bus.repeat_pulse  = rep_q;

endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: directed stimulus with an event scoreboard for an
// active-high and an active-low debounce_multi instance.
module tb_debounce_multi;

   typedef struct {
      int         cyc;
      logic [1:0] db;
      logic [1:0] pr;
      logic [1:0] rl;
      logic [1:0] lg;
      logic [1:0] rp;
   } ev_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   t;
   ev_t  qa[$];
   ev_t  qb[$];
   logic [1:0] prev[2] = '{2'b00, 2'b00};

   debounce_multi_if #(.CHANNELS(2)) ifa ();
   debounce_multi_if #(.CHANNELS(2)) ifb ();

   debounce_multi #(
      .CHANNELS(2), .DB_CYCLES(10), .HOLD_CYCLES(50),
      .REPEAT_CYCLES(20), .ACTIVE_LOW(0)
   ) dut_a (
      .clk(clk), .reset(reset), .bus(ifa)
   );

   debounce_multi #(
      .CHANNELS(2), .DB_CYCLES(10), .HOLD_CYCLES(50),
      .REPEAT_CYCLES(20), .ACTIVE_LOW(1)
   ) dut_b (
      .clk(clk), .reset(reset), .bus(ifb)
   );

   always #20 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic exp_ev(input int id, input int c,
                         input logic [1:0] db, input logic [1:0] pr,
                         input logic [1:0] rl, input logic [1:0] lg,
                         input logic [1:0] rp);
      ev_t e;
      e.cyc = c; e.db = db; e.pr = pr;
      e.rl = rl; e.lg = lg; e.rp = rp;
      if (id == 0) qa.push_back(e);
      else qb.push_back(e);
   endtask

   task automatic chk(input string name, input logic [1:0] got,
                      input logic [1:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %b want %b (cyc %0d)",
                  name, got, want, cyc);
      end
   endtask

   task automatic observe(input int id, input logic [1:0] db,
                          input logic [1:0] pr, input logic [1:0] rl,
                          input logic [1:0] lg, input logic [1:0] rp);
      ev_t e;
      bit  empty;
      if (((pr | rl | lg | rp) == 2'b00) && (db === prev[id])) return;
      prev[id] = db;
      n_cmp++;
      empty = (id == 0) ? (qa.size() == 0) : (qb.size() == 0);
      if (empty) begin
         n_bad++;
         $display("FAIL unexpected_ev dut%0d cyc=%0d db=%b pr=%b rl=%b lg=%b rp=%b want none",
                  id, cyc, db, pr, rl, lg, rp);
         return;
      end
      e = (id == 0) ? qa.pop_front() : qb.pop_front();
      if (e.cyc != cyc || e.db !== db || e.pr !== pr ||
          e.rl !== rl || e.lg !== lg || e.rp !== rp) begin
         n_bad++;
         $display("FAIL event dut%0d got cyc=%0d db=%b pr=%b rl=%b lg=%b rp=%b want cyc=%0d db=%b pr=%b rl=%b lg=%b rp=%b",
                  id, cyc, db, pr, rl, lg, rp,
                  e.cyc, e.db, e.pr, e.rl, e.lg, e.rp);
      end
   endtask

   // Monitor: compare each observed output event against the scoreboard.
   always @(negedge clk) begin
      if (reset) begin
         prev[0] = 2'b00;
         prev[1] = 2'b00;
      end else begin
         observe(0, ifa.db_out, ifa.press_pulse, ifa.release_pulse,
                 ifa.long_pulse, ifa.repeat_pulse);
         observe(1, ifb.db_out, ifb.press_pulse, ifb.release_pulse,
                 ifb.long_pulse, ifb.repeat_pulse);
      end
   end

   // Stimulus: directed scenarios, expected events pushed as issued.
   initial begin
      ifa.button_in = 2'b11;
      ifb.button_in = 2'b11;
      repeat (3) @(negedge clk);
      chk("rst_db_a", ifa.db_out, 2'b00);
      chk("rst_pr_a", ifa.press_pulse, 2'b00);
      chk("rst_rl_a", ifa.release_pulse, 2'b00);
      chk("rst_lg_a", ifa.long_pulse, 2'b00);
      chk("rst_rp_a", ifa.repeat_pulse, 2'b00);
      chk("rst_db_b", ifb.db_out, 2'b00);
      repeat (2) @(negedge clk);

      // Held input through reset: accepted 12 edges after release.
      reset = 1'b0;
      t = cyc;
      exp_ev(0, t + 12, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
      repeat (20) @(negedge clk);
      ifa.button_in = 2'b00;
      exp_ev(0, cyc + 12, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
      repeat (30) @(negedge clk);

      // Bounce on ch0 every 4 cycles, then settle high.
      for (int i = 0; i < 10; i++) begin
         ifa.button_in[0] = (i % 2 == 0);
         repeat (4) @(negedge clk);
      end
      ifa.button_in[0] = 1'b1;
      exp_ev(0, cyc + 12, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
      repeat (22) @(negedge clk);
      ifa.button_in[0] = 1'b0;
      exp_ev(0, cyc + 12, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
      repeat (30) @(negedge clk);

      // Long press with repeats; release lands on a would-be repeat.
      ifa.button_in[0] = 1'b1;
      t = cyc;
      exp_ev(0, t + 12,  2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
      exp_ev(0, t + 62,  2'b01, 2'b00, 2'b00, 2'b01, 2'b00);
      exp_ev(0, t + 82,  2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
      exp_ev(0, t + 102, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
      exp_ev(0, t + 122, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
      exp_ev(0, t + 142, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
      exp_ev(0, t + 162, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
      repeat (150) @(negedge clk);
      ifa.button_in[0] = 1'b0;
      repeat (40) @(negedge clk);

      // Independence: ch0 bounces while ch1 gets a clean press.
      t = cyc;
      ifa.button_in[1] = 1'b1;
      exp_ev(0, t + 12, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
      for (int i = 0; i < 10; i++) begin
         ifa.button_in[0] = (i % 2 == 0);
         repeat (3) @(negedge clk);
      end
      ifa.button_in[1] = 1'b0;
      exp_ev(0, cyc + 12, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00);
      repeat (30) @(negedge clk);

      // Reset while the debounce counter is at 7.
      ifa.button_in[0] = 1'b1;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midcnt_db", ifa.db_out, 2'b00);
      chk("midcnt_pr", ifa.press_pulse, 2'b00);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      exp_ev(0, cyc + 12, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
      repeat (40) @(negedge clk);

      // Reset during hold: level drops at once, no release pulse.
      reset = 1'b1;
      #1;
      chk("midhold_db", ifa.db_out, 2'b00);
      chk("midhold_rl", ifa.release_pulse, 2'b00);
      chk("midhold_lg", ifa.long_pulse, 2'b00);
      ifa.button_in = 2'b00;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);

      // Active-low instance: idle-high never pressed; drive low.
      ifb.button_in = 2'b00;
      exp_ev(1, cyc + 12, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
      repeat (20) @(negedge clk);
      ifb.button_in = 2'b11;
      exp_ev(1, cyc + 12, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
      repeat (30) @(negedge clk);

      n_cmp++;
      if (qa.size() != 0) begin
         n_bad++;
         $display("FAIL leftover_a: got %0d pending want 0", qa.size());
      end
      n_cmp++;
      if (qb.size() != 0) begin
         n_bad++;
         $display("FAIL leftover_b: got %0d pending want 0", qb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
